mac_dot_scheduler: RTL and testbench

Job controller wrapped around an embedded 3-stage multiply-accumulate datapath (operand register -> product register -> saturating accumulator). Accepts a job of `len` operand pairs and streams them in over a valid/ready handshake, inserting bubbles when the source stalls. It drains the pipeline, then presents the dot-product result on a valid/ready output. It lets the vector unit run back-to-back dot products without resetting the MAC between jobs.

---
 rtl/mac_dot_scheduler_if.sv | 29 ++
 rtl/mac_dot_scheduler.sv | 122 ++++++++++++
 tb/tb_mac_dot_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_scheduler_if.sv
// mac_dot_scheduler_if
//   Operand stream and result handshake bundle for mac_dot_scheduler.
//   master : operand source / result consumer (drives op_*, res_ready)
//   slave  : the scheduler (drives op_ready, res_valid, res, res_of)
//   op_valid/op_ready/op_a/op_b : operand pair stream
//   res_valid/res_ready/res/res_of : dot-product result and saturation flag
interface mac_dot_scheduler_if #(
   parameter int DW = 8,
   parameter int AW = 16
);
   logic          op_valid;
   logic          op_ready;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic          res_valid;
   logic          res_ready;
   logic [AW-1:0] res;
   logic          res_of;

   modport master (
      output op_valid, op_a, op_b, res_ready,
      input  op_ready, res_valid, res, res_of
   );

   modport slave (
      input  op_valid, op_a, op_b, res_ready,
      output op_ready, res_valid, res, res_of
   );
endinterface

// File: rtl/mac_dot_scheduler.sv
// mac_dot_scheduler
//   Job controller around a 3-stage MAC (operand reg -> product reg ->
//   saturating accumulator). A job of `len` operand pairs is streamed in,
//   the pipe is drained, and the dot product is offered on a valid/ready
//   result port. The accumulator is cleared per job, so jobs run
//   back-to-back without a reset.
// Ports:
//   clk   : rising-edge clock
//   r     : asynchronous active-low reset
//   start : job request (IDLE only); len : pair count sampled with start
//   busy  : high in FEED, DRAIN, DONE
//   bus   : operand stream + result handshake (slave modport)
//   abort : only when MAC_ABORT_EN is defined; kills a job in FEED/DRAIN
// Build option: define MAC_ABORT_EN to add the abort input.
module mac_dot_scheduler #(
   parameter int DW    = 8,
   parameter int AW    = 16,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             r,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
`ifdef MAC_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   mac_dot_scheduler_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, cnt_q;
   logic [2:1]        vld_pipe;           // stage valid tags v1, v2
   logic [DW-1:0]     a1, b1;
   logic [2*DW-1:0]   p2;
   logic [AW-1:0]     acc;
   logic              of_q;
   logic [AW:0]       sum;
   logic              fire, start_job, abort_hit;

`ifdef MAC_ABORT_EN
   assign abort_hit = abort & ((state_q == FEED) | (state_q == DRAIN));
`else
   assign abort_hit = 1'b0;
`endif

   assign fire      = (state_q == FEED) & bus.op_valid;
   assign start_job = (state_q == IDLE) & start;

   // one extra bit catches the carry out of the accumulator
   assign sum = {1'b0, acc} + {{(AW+1-2*DW){1'b0}}, p2};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = (len == '0) ? DONE : FEED;
         FEED:  if (abort_hit) state_d = IDLE;
                else if (fire && cnt_q == len_q - LEN_W'(1)) state_d = DRAIN;
         // last product sits in stage 2 with nothing behind it in stage 1:
         // it accumulates on this edge, so the result is ready after it
         DRAIN: if (abort_hit) state_d = IDLE;
                else if (vld_pipe[2] && !vld_pipe[1]) state_d = DONE;
         DONE:  if (bus.res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) state_q <= IDLE;
      else    state_q <= state_d;
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         len_q    <= '0;
         cnt_q    <= '0;
         vld_pipe <= '0;
         a1       <= '0;
         b1       <= '0;
         p2       <= '0;
         acc      <= '0;
         of_q     <= 1'b0;
      end else begin
         vld_pipe[1] <= fire & ~abort_hit;
         vld_pipe[2] <= vld_pipe[1] & ~abort_hit;
         if (fire) begin
            a1 <= bus.op_a;
            b1 <= bus.op_b;
         end
         p2 <= {{DW{1'b0}}, a1} * {{DW{1'b0}}, b1};

         if (start_job) begin
            len_q <= len;
            cnt_q <= '0;
            acc   <= '0;
            of_q  <= 1'b0;
         end else if (abort_hit) begin
            cnt_q <= '0;
            acc   <= '0;
         end else begin
            if (fire) cnt_q <= cnt_q + LEN_W'(1);
            if (vld_pipe[2]) begin
               if (sum[AW]) begin
                  acc  <= '1;
                  of_q <= 1'b1;
               end else begin
                  acc  <= sum[AW-1:0];
               end
            end
         end
      end
   end

   assign busy          = (state_q != IDLE);
   assign bus.op_ready  = (state_q == FEED);
   assign bus.res_valid = (state_q == DONE);
   assign bus.res       = acc;
   assign bus.res_of    = of_q;

endmodule

// File: tb/tb_mac_dot_scheduler.sv
// tb_mac_dot_scheduler
//   Directed bench for mac_dot_scheduler: basic job, bubbles, saturation,
//   zero length with result backpressure, reset mid-job, and (when
//   MAC_ABORT_EN is defined) abort. Expected values are hand-computed.
module tb_mac_dot_scheduler;
   localparam int DW = 8, AW = 16, LEN_W = 8;

   logic             clk = 1'b0;
   logic             r = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic             busy;
`ifdef MAC_ABORT_EN
   logic             abort = 1'b0;
`endif
   int               checks = 0;
   int               errors = 0;

   mac_dot_scheduler_if #(.DW(DW), .AW(AW)) bus ();

   mac_dot_scheduler #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .r     (r),
      .start (start),
      .len   (len),
`ifdef MAC_ABORT_EN
      .abort (abort),
`endif
      .busy  (busy),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_job(input logic [LEN_W-1:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   // presents one pair and returns just after the accept edge
   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int n = 0;
      bus.op_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      while (!bus.op_ready && n < 20) begin
         tick();
         n++;
      end
      chk("op_ready_at_send", {31'b0, bus.op_ready}, 32'd1);
      chk("busy_at_send", {31'b0, busy}, 32'd1);
      tick();
      bus.op_valid = 1'b0;
   endtask

   // after the last accept edge: result must appear exactly 2 edges later
   task automatic expect_result(input string tag, input logic [AW-1:0] exp_res, input logic exp_of);
      chk({tag, "_rv_e0"}, {31'b0, bus.res_valid}, 32'd0);
      chk({tag, "_ordy_drain"}, {31'b0, bus.op_ready}, 32'd0);
      tick();
      chk({tag, "_rv_e1"}, {31'b0, bus.res_valid}, 32'd0);
      tick();
      chk({tag, "_rv_e2"}, {31'b0, bus.res_valid}, 32'd1);
      chk({tag, "_res"}, {16'b0, bus.res}, {16'b0, exp_res});
      chk({tag, "_of"}, {31'b0, bus.res_of}, {31'b0, exp_of});
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk({tag, "_rv_after"}, {31'b0, bus.res_valid}, 32'd0);
      chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      bus.op_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.res_ready = 1'b0;

      // reset state
      #2;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_op_ready", {31'b0, bus.op_ready}, 32'd0);
      chk("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
      chk("rst_res", {16'b0, bus.res}, 32'd0);
      chk("rst_res_of", {31'b0, bus.res_of}, 32'd0);
      tick();
      r = 1'b1;
      tick();

      // basic: 2*3 + 4*5 + 6*7 = 68
      begin_job(8'd3);
      chk("basic_busy", {31'b0, busy}, 32'd1);
      send(8'd2, 8'd3);
      send(8'd4, 8'd5);
      send(8'd6, 8'd7);
      expect_result("basic", 16'h0044, 1'b0);

      // bubbles: two idle cycles between pairs, op_ready stays high
      begin_job(8'd3);
      send(8'd2, 8'd3);
      tick(); chk("bub_ordy_a", {31'b0, bus.op_ready}, 32'd1);
      tick(); chk("bub_ordy_b", {31'b0, bus.op_ready}, 32'd1);
      send(8'd4, 8'd5);
      tick(); chk("bub_ordy_c", {31'b0, bus.op_ready}, 32'd1);
      tick(); chk("bub_ordy_d", {31'b0, bus.op_ready}, 32'd1);
      send(8'd6, 8'd7);
      expect_result("bubble", 16'h0044, 1'b0);

      // saturation: 0xFE01 + 0xFE01 overflows 16 bits
      begin_job(8'd3);
      send(8'd255, 8'd255);
      send(8'd255, 8'd255);
      send(8'd1, 8'd1);
      expect_result("sat", 16'hFFFF, 1'b1);
      begin_job(8'd1);
      send(8'd1, 8'd1);
      expect_result("post_sat", 16'h0001, 1'b0);

      // zero length with result backpressure; start ignored in DONE
      begin_job(8'd0);
      chk("zl_rv", {31'b0, bus.res_valid}, 32'd1);
      chk("zl_res", {16'b0, bus.res}, 32'd0);
      chk("zl_of", {31'b0, bus.res_of}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         start = i[0];
         len   = 8'd3;
         tick();
         chk("bp_rv", {31'b0, bus.res_valid}, 32'd1);
         chk("bp_res", {16'b0, bus.res}, 32'd0);
         chk("bp_ordy", {31'b0, bus.op_ready}, 32'd0);
      end
      start = 1'b0;
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk("bp_rv_done", {31'b0, bus.res_valid}, 32'd0);
      chk("bp_idle", {31'b0, busy}, 32'd0);

      // reset mid-job: 5*5 already accumulated when reset hits
      begin_job(8'd4);
      send(8'd5, 8'd5);
      send(8'd2, 8'd2);
      tick();
      chk("pre_rst_res", {16'b0, bus.res}, 32'd25);
      r = 1'b0;
      #1;
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_ordy", {31'b0, bus.op_ready}, 32'd0);
      chk("mid_rst_rv", {31'b0, bus.res_valid}, 32'd0);
      chk("mid_rst_res", {16'b0, bus.res}, 32'd0);
      chk("mid_rst_of", {31'b0, bus.res_of}, 32'd0);
      tick();
      r = 1'b1;
      tick();
      chk("post_rst_idle", {31'b0, busy}, 32'd0);
      begin_job(8'd1);
      send(8'd3, 8'd3);
      expect_result("post_rst", 16'h0009, 1'b0);

`ifdef MAC_ABORT_EN
      // abort after two accepts, then a clean job: 1*2 + 3*4 = 14
      begin_job(8'd4);
      send(8'd9, 8'd9);
      send(8'd9, 8'd9);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_ordy", {31'b0, bus.op_ready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("abort_no_rv", {31'b0, bus.res_valid}, 32'd0);
      end
      begin_job(8'd2);
      send(8'd1, 8'd2);
      send(8'd3, 8'd4);
      expect_result("post_abort", 16'h000E, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // hard stop so the bench cannot hang
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
